eth_preprocess: RTL and testbench

// Ingress word tracker; sits directly upstream of eth_parser and of the IP checker/lookup stages.
// - Skips module-header words.
// - Indexes the Ethernet/IPv4 header words of each packet on a 32-bit data path.
// - Outputs one-cycle word strobes, registered in step with a delayed copy of the data.
// - Downstream stages latch fields with "if (strobe) reg <= in_data".
// - Flags runt packets whose EOP arrives before the end of the IPv4 header.

---
 rtl/eth_preprocess.sv | 125 ++++++++++++
 tb/tb_eth_preprocess.sv | 116 +++++++++++
 2 files changed

// File: rtl/eth_preprocess.sv
// eth_preprocess: skips module headers, strobes the Ethernet/IPv4 header words one cycle behind the data and flags runt packets.
module eth_preprocess #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  word_MAC_DA_HI,
  output logic                  word_MAC_DASA,
  output logic                  word_MAC_SA_LO,
  output logic                  word_ETH_IP_VER,
  output logic                  word_IP_LEN_ID,
  output logic                  word_IP_FRAG_TTL_PROTO,
  output logic                  word_IP_CHKSUM_SRC_HI,
  output logic                  word_IP_SRC_DST,
  output logic                  word_IP_DST_LO,
  output logic                  pkt_runt,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  runt_count
);
  typedef enum logic [1:0] {SKIP_HDRS, HDR_WORDS, WAIT_EOP} state_t;
  state_t                r_state, w_state_nxt;
  logic [3:0]            r_idx, w_idx_nxt;
  logic [8:0]            r_strb, w_strb;
  logic                  r_runt, w_runt, w_pkt_done, w_ctrl_nz;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic                  r_wr;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt, r_runt_cnt;

  assign in_rdy    = out_rdy;
  assign w_ctrl_nz = |in_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SKIP_HDRS;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (in_wr)
      case (r_state)
        SKIP_HDRS: if (!w_ctrl_nz) begin
          w_state_nxt = HDR_WORDS;
          w_idx_nxt   = 4'd1;
        end
        HDR_WORDS: if (w_ctrl_nz) begin
          w_state_nxt = SKIP_HDRS;
          w_idx_nxt   = 4'd0;
        end else if (r_idx == 4'd8) w_state_nxt = WAIT_EOP;
        else w_idx_nxt = r_idx + 4'd1;
        WAIT_EOP: if (w_ctrl_nz) begin
          w_state_nxt = SKIP_HDRS;
          w_idx_nxt   = 4'd0;
        end
        default: begin
          w_state_nxt = SKIP_HDRS;
          w_idx_nxt   = 4'd0;
        end
      endcase
  end

  always_comb begin
    w_strb     = !in_wr ? 9'd0 :
                 r_state == SKIP_HDRS ? (w_ctrl_nz ? 9'd0 : 9'd1) :
                 r_state == HDR_WORDS ? 9'd1 << r_idx : 9'd0;
    w_runt     = in_wr && w_ctrl_nz && r_state == HDR_WORDS && r_idx < 4'd8;
    w_pkt_done = in_wr && w_ctrl_nz && r_state != SKIP_HDRS;
  end

  // data, strobes and pulse share one register stage so they stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= '0;
      r_ctrl     <= '0;
      r_wr       <= 1'b0;
      r_strb     <= 9'd0;
      r_runt     <= 1'b0;
      r_pkt_cnt  <= '0;
      r_runt_cnt <= '0;
    end else begin
      r_data     <= in_data;
      r_ctrl     <= in_ctrl;
      r_wr       <= in_wr;
      r_strb     <= w_strb;
      r_runt     <= w_runt;
      r_pkt_cnt  <= w_pkt_done ? r_pkt_cnt + 1'b1 : r_pkt_cnt;
      r_runt_cnt <= (w_runt && r_runt_cnt != '1) ? r_runt_cnt + 1'b1 : r_runt_cnt;
    end
  end

  assign out_data               = r_data;
  assign out_ctrl               = r_ctrl;
  assign out_wr                 = r_wr;
  assign word_MAC_DA_HI         = r_strb[0];
  assign word_MAC_DASA          = r_strb[1];
  assign word_MAC_SA_LO         = r_strb[2];
  assign word_ETH_IP_VER        = r_strb[3];
  assign word_IP_LEN_ID         = r_strb[4];
  assign word_IP_FRAG_TTL_PROTO = r_strb[5];
  assign word_IP_CHKSUM_SRC_HI  = r_strb[6];
  assign word_IP_SRC_DST        = r_strb[7];
  assign word_IP_DST_LO         = r_strb[8];
  assign pkt_runt               = r_runt;
  assign pkt_count              = r_pkt_cnt;
  assign runt_count             = r_runt_cnt;

  a_one_strobe: assert property (@(posedge clk) disable iff (reset) $onehot0(r_strb));
  a_wr_when_rdy: assert property (@(posedge clk) disable iff (reset) !(in_wr && !in_rdy));
endmodule

// File: tb/tb_eth_preprocess.sv
// tb_eth_preprocess: directed checks of header strobes, runt detection and counters of eth_preprocess.
module tb_eth_preprocess;
  logic        clk = 1'b0;
  logic        reset, in_wr, out_rdy, in_rdy, out_wr, pkt_runt;
  logic [31:0] in_data, out_data, pkt_count, runt_count;
  logic [3:0]  in_ctrl, out_ctrl;
  logic        s0, s1, s2, s3, s4, s5, s6, s7, s8;
  logic [8:0]  strb;
  int          n_chk = 0;
  int          n_fail = 0;

  eth_preprocess dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .word_MAC_DA_HI(s0), .word_MAC_DASA(s1), .word_MAC_SA_LO(s2), .word_ETH_IP_VER(s3),
    .word_IP_LEN_ID(s4), .word_IP_FRAG_TTL_PROTO(s5), .word_IP_CHKSUM_SRC_HI(s6),
    .word_IP_SRC_DST(s7), .word_IP_DST_LO(s8), .pkt_runt(pkt_runt),
    .pkt_count(pkt_count), .runt_count(runt_count)
  );

  assign strb = {s8, s7, s6, s5, s4, s3, s2, s1, s0};
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] d, input logic [3:0] c, input logic w,
                      input logic [8:0] es, input logic er);
    in_data = d; in_ctrl = c; in_wr = w;
    @(posedge clk); #1;
    chk("out_wr", out_wr, w);
    chk("strobes", strb, es);
    chk("pkt_runt", pkt_runt, er);
    if (w) begin
      chk("out_data", out_data, d);
      chk("out_ctrl", out_ctrl, c);
    end
  endtask

  task automatic idle();
    step(32'h5A5A_5A5A, 4'h0, 1'b0, 9'd0, 1'b0);
  endtask

  task automatic send_pkt(input int id, input int n_hdr, input int n_words, input bit gaps);
    bit last;
    for (int h = 0; h < n_hdr; h++) begin
      step(32'hF000_0000 | (id << 8) | h, 4'hF, 1'b1, 9'd0, 1'b0);
      if (gaps) idle();
    end
    for (int i = 0; i < n_words; i++) begin
      last = (i == n_words - 1);
      step(32'hA000_0000 | (id << 8) | i, last ? 4'h1 : 4'h0, 1'b1,
           i < 9 ? 9'(1) << i : 9'd0, last && i < 8);
      if (gaps) idle();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_wr = 1'b1; in_data = 32'hDEAD_BEEF; in_ctrl = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_wr", out_wr, 1'b0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_ctrl", out_ctrl, 4'd0);
    chk("rst strobes", strb, 9'd0);
    chk("rst pkt_runt", pkt_runt, 1'b0);
    chk("rst pkt_count", pkt_count, 32'd0);
    chk("rst runt_count", runt_count, 32'd0);
    in_wr = 1'b0; in_ctrl = 4'h0; reset = 1'b0;
  endtask

  initial begin
    out_rdy = 1'b1;
    do_reset();
    out_rdy = 1'b0; #1;
    chk("in_rdy low", in_rdy, 1'b0);
    out_rdy = 1'b1; #1;
    chk("in_rdy high", in_rdy, 1'b1);
    idle();
    send_pkt(1, 2, 16, 1'b0);
    chk("full pkt_count", pkt_count, 32'd1);
    chk("full runt_count", runt_count, 32'd0);
    send_pkt(2, 2, 16, 1'b1);
    chk("gap pkt_count", pkt_count, 32'd2);
    chk("gap runt_count", runt_count, 32'd0);
    do_reset();
    send_pkt(3, 1, 5, 1'b0);
    chk("runt pkt_count", pkt_count, 32'd1);
    chk("runt runt_count", runt_count, 32'd1);
    send_pkt(4, 1, 9, 1'b0);
    chk("idx8 pkt_count", pkt_count, 32'd2);
    chk("idx8 runt_count", runt_count, 32'd1);
    send_pkt(5, 1, 12, 1'b0);
    chk("after idx8 pkt_count", pkt_count, 32'd3);
    do_reset();
    for (int p = 0; p < 100; p++) send_pkt(p, 1, 16, 1'b0);
    chk("b2b pkt_count", pkt_count, 32'd100);
    chk("b2b runt_count", runt_count, 32'd0);
    do_reset();
    for (int p = 1; p < 50; p++) send_pkt(p, 1, 16, 1'b0);
    chk("pre-reset pkt_count", pkt_count, 32'd49);
    step(32'hF000_3200, 4'hF, 1'b1, 9'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(32'hA000_3200 | i, 4'h0, 1'b1, 9'(1) << i, 1'b0);
    do_reset();
    send_pkt(51, 1, 16, 1'b0);
    chk("restart pkt_count", pkt_count, 32'd1);
    chk("restart runt_count", runt_count, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
